alu_arbiter: RTL

Shares one instance of the team's 32-bit combinational `alu` among up to four requesters, such as the integer pipe and the address/branch helper.
- Arbitration is round-robin with a valid/ready handshake on each request port and a single valid/ready response port.
- Operands and opcode are registered before the ALU. The result, Zero and requester ID are registered after it.
- MUL is given extra settle cycles for timing closure.
- Unsupported opcodes are trapped and reported instead of being passed to the ALU.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu.sv | 37 +++
 rtl/rr_pick.sv | 30 +++
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, legality check and arbiter FSM states.
// Ports: none (package).
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_NOR  = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SLT  = 4'h7;
    localparam logic [3:0] ALU_MUL  = 4'h9;
    localparam logic [3:0] ALU_SLL  = 4'hA;
    localparam logic [3:0] ALU_SLTU = 4'hE;
    localparam logic [3:0] ALU_SRA  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    function automatic logic alu_op_legal(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_NOR,
            ALU_XOR, ALU_SUB, ALU_SLT, ALU_MUL,
            ALU_SLL, ALU_SLTU, ALU_SRA: alu_op_legal = 1'b1;
            default:                    alu_op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; all results truncated to 32 bits.
// Ports: i_alu_ctrl opcode, i_a/i_b operands, o_result, o_zero (result == 0).
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  i_alu_ctrl,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_zero
);

    logic [31:0] w_prod;

    assign w_prod = i_a * i_b;

    always_comb begin
        o_result = '0;
        case (i_alu_ctrl)
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_ADD:  o_result = i_a + i_b;
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLT:  o_result = {31'b0, $signed(i_a) < $signed(i_b)};
            ALU_MUL:  o_result = w_prod;
            ALU_SLL:  o_result = i_a << i_b[4:0];
            ALU_SLTU: o_result = {31'b0, i_a < i_b};
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
            default:  o_result = '0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first request at or after i_ptr, searching upward with wrap.
// Ports: i_req request vector, i_ptr start index, o_gnt one-hot, o_idx index, o_any.
module rr_pick #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    always_comb begin
        int j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NREQ requesters with registered in/out stages.
// Ports: clk, rst_n, Req* per-requester handshake/operands, Rsp* single response port.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MUL_STALL = 2,
    parameter int IDW       = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      ReqValid,
    output logic [NREQ-1:0]      ReqReady,
    input  logic [4*NREQ-1:0]    ReqOp,
    input  logic [32*NREQ-1:0]   ReqA,
    input  logic [32*NREQ-1:0]   ReqB,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [IDW-1:0]       RspId,
    output logic [31:0]          RspResult,
    output logic                 RspZero,
    output logic                 RspErr
);

    arb_state_t      r_state;
    arb_state_t      w_next;
    logic [3:0]      r_op;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  r_rr_ptr;
    logic [2:0]      r_stall_cnt;
    logic            r_trap;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic [3:0]      w_sel_op;
    logic [3:0]      w_alu_op;
    logic [31:0]     w_alu_result;
    logic            w_alu_zero;
    logic            w_capture;
    logic            w_stall_dec;
    logic            w_finish;
    logic            w_rsp_hs;

    rr_pick #(.N(NREQ), .IDW(IDW)) u_rr_pick (
        .i_req (ReqValid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_sel_op = ReqOp[4*int'(w_idx) +: 4];

    // Trapped opcodes never reach the ALU; it sees a harmless AND instead.
    assign w_alu_op = r_trap ? ALU_AND : r_op;

    alu u_alu (
        .i_alu_ctrl (w_alu_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_result   (w_alu_result),
        .o_zero     (w_alu_zero)
    );

    // rst_n gating keeps ReqReady low while reset is held.
    assign ReqReady = (rst_n && r_state == ST_IDLE) ? w_gnt : '0;
    assign RspValid = (r_state == ST_RESP);

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_stall_dec = 1'b0;
        w_finish    = 1'b0;
        w_rsp_hs    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_capture = 1'b1;
                    w_next    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_stall_cnt != 3'd0) begin
                    w_stall_dec = 1'b1;
                end else begin
                    w_finish = 1'b1;
                    w_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (RspReady) begin
                    w_rsp_hs = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_trap      <= 1'b0;
            r_stall_cnt <= '0;
            r_rr_ptr    <= '0;
            RspId       <= '0;
            RspResult   <= '0;
            RspZero     <= 1'b0;
            RspErr      <= 1'b0;
        end else begin
            if (w_capture) begin
                r_op        <= w_sel_op;
                r_a         <= ReqA[32*int'(w_idx) +: 32];
                r_b         <= ReqB[32*int'(w_idx) +: 32];
                r_id        <= w_idx;
                r_trap      <= !alu_op_legal(w_sel_op);
                r_stall_cnt <= (w_sel_op == ALU_MUL) ? 3'(MUL_STALL) : 3'd0;
            end else if (w_stall_dec) begin
                r_stall_cnt <= r_stall_cnt - 3'd1;
            end
            if (w_finish) begin
                RspResult <= r_trap ? 32'd0 : w_alu_result;
                RspZero   <= !r_trap && w_alu_zero;
                RspErr    <= r_trap;
                RspId     <= r_id;
            end
            if (w_rsp_hs) begin
                r_rr_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

endmodule
